// File: rtl/decode_2ri14_queue.sv
// Multi-lane decoder for the LL.W / SC.W / CSR instruction group, feeding a
// circular queue of decoded entries that presents up to LANES heads per cycle.
// CSR writers are issued alone on lane 0 so the consumer never sees two
// CSR side effects in the same cycle.
module decode_2ri14_queue #(
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LANES-1:0]      in_valid,
    input  logic [32*LANES-1:0]   in_pc,
    input  logic [32*LANES-1:0]   in_inst,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_valid,
    output logic [32*LANES-1:0]   pc_out,
    output logic [32*LANES-1:0]   inst_out,
    output logic [LANES-1:0]      inst_valid,
    output logic [LANES-1:0]      is_exception,
    output logic [7*LANES-1:0]    exception_cause,
    output logic [LANES-1:0]      reg_write_en,
    output logic [5*LANES-1:0]    reg_write_addr,
    output logic [8*LANES-1:0]    aluop,
    output logic [3*LANES-1:0]    alusel,
    output logic [32*LANES-1:0]   imm,
    output logic [LANES-1:0]      reg1_read_en,
    output logic [5*LANES-1:0]    reg1_read_addr,
    output logic [LANES-1:0]      reg2_read_en,
    output logic [5*LANES-1:0]    reg2_read_addr,
    output logic [LANES-1:0]      is_privilege,
    output logic [LANES-1:0]      csr_read_en,
    output logic [LANES-1:0]      csr_write_en,
    output logic [14*LANES-1:0]   csr_addr
);

    // Shared pipeline encodings (kept identical to the core-wide defines)
    localparam logic [7:0]  ALU_NOP            = 8'h00;
    localparam logic [7:0]  ALU_LLW            = 8'h2A;
    localparam logic [7:0]  ALU_SCW            = 8'h2B;
    localparam logic [7:0]  ALU_CSRRD          = 8'h30;
    localparam logic [7:0]  ALU_CSRWR          = 8'h31;
    localparam logic [7:0]  ALU_CSRXCHG        = 8'h32;
    localparam logic [2:0]  ALU_SEL_NOP        = 3'b000;
    localparam logic [2:0]  ALU_SEL_CSR        = 3'b110;
    localparam logic [2:0]  ALU_SEL_LOAD_STORE = 3'b111;
    localparam logic [6:0]  EXCEPTION_INE      = 7'h0D;
    localparam logic [13:0] CSR_LLBCTL         = 14'h060;

    localparam logic [7:0]  OP_CSR = 8'h04;
    localparam logic [7:0]  OP_LLW = 8'h20;
    localparam logic [7:0]  OP_SCW = 8'h21;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - LANES);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        inst_valid;
        logic        is_exception;
        logic [6:0]  exception_cause;
        logic        reg_write_en;
        logic [4:0]  reg_write_addr;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] imm;
        logic        reg1_read_en;
        logic [4:0]  reg1_read_addr;
        logic        reg2_read_en;
        logic [4:0]  reg2_read_addr;
        logic        is_privilege;
        logic        csr_read_en;
        logic        csr_write_en;
        logic [13:0] csr_addr;
    } entry_t;

    // Entry used for unrecognised opcodes and for idle output lanes
    function automatic entry_t illegal_entry();
        entry_t e;
        e                 = '0;
        e.is_exception    = 1'b1;
        e.exception_cause = EXCEPTION_INE;
        e.aluop           = ALU_NOP;
        e.alusel          = ALU_SEL_NOP;
        return e;
    endfunction

    function automatic entry_t decode_inst(input logic [31:0] pc, input logic [31:0] inst);
        entry_t      e;
        logic [7:0]  opcode;
        logic [13:0] si14;
        logic [4:0]  rj;
        logic [4:0]  rd;
        opcode = inst[31:24];
        si14   = inst[23:10];
        rj     = inst[9:5];
        rd     = inst[4:0];
        e      = illegal_entry();
        e.pc   = pc;
        e.inst = inst;
        case (opcode)
            OP_LLW, OP_SCW: begin
                e.inst_valid      = 1'b1;
                e.is_exception    = 1'b0;
                e.exception_cause = '0;
                e.aluop           = (opcode == OP_LLW) ? ALU_LLW : ALU_SCW;
                e.alusel          = ALU_SEL_LOAD_STORE;
                e.reg1_read_en    = 1'b1;
                e.reg1_read_addr  = rj;
                e.reg_write_en    = 1'b1;
                e.reg_write_addr  = rd;
                e.imm             = {{16{si14[13]}}, si14, 2'b00};
                e.csr_read_en     = 1'b1;
                e.csr_addr        = CSR_LLBCTL;
                if (opcode == OP_SCW) begin
                    e.reg2_read_en   = 1'b1;
                    e.reg2_read_addr = rd;
                end
            end
            OP_CSR: begin
                e.inst_valid      = 1'b1;
                e.is_exception    = 1'b0;
                e.exception_cause = '0;
                e.is_privilege    = 1'b1;
                e.alusel          = ALU_SEL_CSR;
                e.reg_write_en    = 1'b1;
                e.reg_write_addr  = rd;
                e.csr_read_en     = 1'b1;
                e.csr_addr        = si14;
                if (rj == 5'd0) begin
                    e.aluop = ALU_CSRRD;
                end else if (rj == 5'd1) begin
                    e.aluop          = ALU_CSRWR;
                    e.reg1_read_en   = 1'b1;
                    e.reg1_read_addr = rd;
                    e.csr_write_en   = 1'b1;
                end else begin
                    e.aluop          = ALU_CSRXCHG;
                    e.reg1_read_en   = 1'b1;
                    e.reg1_read_addr = rd;
                    e.reg2_read_en   = 1'b1;
                    e.reg2_read_addr = rj;
                    e.csr_write_en   = 1'b1;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
        int sum;
        sum = (int'(base) + offs) % DEPTH;
        return PTR_W'(sum);
    endfunction

    entry_t           queue_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    entry_t           dec     [LANES];
    logic [LANES-1:0] lane_take;
    logic [CNT_W-1:0] enq_n;
    logic             enq_fire;

    entry_t           lane_entry [LANES];
    logic [LANES-1:0] lane_present;
    logic [CNT_W-1:0] present_n;
    logic             deq_fire;
    entry_t           sel;

    assign in_ready = (count <= READY_MAX);
    assign enq_fire = in_valid[0] & in_ready & ~flush;
    assign deq_fire = out_ready & lane_present[0] & ~flush;
    assign out_valid = lane_present;

    // Decode every incoming lane and find the contiguous run of valid lanes
    always_comb begin
        logic run;
        run       = 1'b1;
        enq_n     = '0;
        lane_take = '0;
        for (int k = 0; k < LANES; k++) begin
            dec[k]       = decode_inst(in_pc[k*32 +: 32], in_inst[k*32 +: 32]);
            run          = run & in_valid[k];
            lane_take[k] = run;
            if (run) begin
                enq_n = enq_n + CNT_W'(1);
            end
        end
    end

    // Pick the head entries to present, stopping at or just after a CSR writer
    always_comb begin
        logic stop;
        stop         = 1'b0;
        present_n    = '0;
        lane_present = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_entry[k] = queue_mem[wrap_add(head, k)];
            if (!stop && (CNT_W'(k) < count)) begin
                if (lane_entry[k].csr_write_en && (k != 0)) begin
                    stop = 1'b1;
                end else begin
                    lane_present[k] = 1'b1;
                    present_n       = present_n + CNT_W'(1);
                    if (lane_entry[k].csr_write_en) begin
                        stop = 1'b1;
                    end
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Drive per-lane outputs from storage, idle lanes show the illegal-entry values
    always_comb begin
        pc_out          = '0;
        inst_out        = '0;
        inst_valid      = '0;
        is_exception    = '0;
        exception_cause = '0;
        reg_write_en    = '0;
        reg_write_addr  = '0;
        aluop           = '0;
        alusel          = '0;
        imm             = '0;
        reg1_read_en    = '0;
        reg1_read_addr  = '0;
        reg2_read_en    = '0;
        reg2_read_addr  = '0;
        is_privilege    = '0;
        csr_read_en     = '0;
        csr_write_en    = '0;
        csr_addr        = '0;
        sel             = illegal_entry();
        for (int k = 0; k < LANES; k++) begin
            sel = lane_present[k] ? lane_entry[k] : illegal_entry();
            pc_out[k*32 +: 32]         = sel.pc;
            inst_out[k*32 +: 32]       = sel.inst;
            inst_valid[k]              = sel.inst_valid;
            is_exception[k]            = sel.is_exception;
            exception_cause[k*7 +: 7]  = sel.exception_cause;
            reg_write_en[k]            = sel.reg_write_en;
            reg_write_addr[k*5 +: 5]   = sel.reg_write_addr;
            aluop[k*8 +: 8]            = sel.aluop;
            alusel[k*3 +: 3]           = sel.alusel;
            imm[k*32 +: 32]            = sel.imm;
            reg1_read_en[k]            = sel.reg1_read_en;
            reg1_read_addr[k*5 +: 5]   = sel.reg1_read_addr;
            reg2_read_en[k]            = sel.reg2_read_en;
            reg2_read_addr[k*5 +: 5]   = sel.reg2_read_addr;
            is_privilege[k]            = sel.is_privilege;
            csr_read_en[k]             = sel.csr_read_en;
            csr_write_en[k]            = sel.csr_write_en;
            csr_addr[k*14 +: 14]       = sel.csr_addr;
        end
    end

    // Write accepted lanes into storage at the tail, in lane order
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_take[k]) begin
                    queue_mem[wrap_add(tail, k)] <= dec[k];
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over any same-cycle traffic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                tail <= wrap_add(tail, int'(enq_n));
            end
            if (deq_fire) begin
                head <= wrap_add(head, int'(present_n));
            end
            count <= count + (enq_fire ? enq_n : '0) - (deq_fire ? present_n : '0);
        end
    end

endmodule

// File: tb/tb_decode_2ri14_queue.sv
// Scoreboard bench for decode_2ri14_queue: expected decoded entries are queued
// when a bundle is accepted and compared against the lanes the DUT presents.
module tb_decode_2ri14_queue;

    localparam int LANES = 2;
    localparam int DEPTH = 4;

    localparam logic [7:0]  ALU_NOP            = 8'h00;
    localparam logic [7:0]  ALU_LLW            = 8'h2A;
    localparam logic [7:0]  ALU_SCW            = 8'h2B;
    localparam logic [7:0]  ALU_CSRRD          = 8'h30;
    localparam logic [7:0]  ALU_CSRWR          = 8'h31;
    localparam logic [7:0]  ALU_CSRXCHG        = 8'h32;
    localparam logic [2:0]  ALU_SEL_NOP        = 3'b000;
    localparam logic [2:0]  ALU_SEL_CSR        = 3'b110;
    localparam logic [2:0]  ALU_SEL_LOAD_STORE = 3'b111;
    localparam logic [6:0]  EXCEPTION_INE      = 7'h0D;
    localparam logic [13:0] CSR_LLBCTL         = 14'h060;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        iv;
        logic        exc;
        logic [6:0]  cause;
        logic        rwe;
        logic [4:0]  rwa;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] imm;
        logic        r1e;
        logic [4:0]  r1a;
        logic        r2e;
        logic [4:0]  r2a;
        logic        priv;
        logic        cre;
        logic        cwe;
        logic [13:0] caddr;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic [LANES-1:0]    in_valid;
    logic [32*LANES-1:0] in_pc;
    logic [32*LANES-1:0] in_inst;
    logic                in_ready;
    logic                flush;
    logic                out_ready;
    logic [LANES-1:0]    out_valid;
    logic [32*LANES-1:0] pc_out;
    logic [32*LANES-1:0] inst_out;
    logic [LANES-1:0]    inst_valid;
    logic [LANES-1:0]    is_exception;
    logic [7*LANES-1:0]  exception_cause;
    logic [LANES-1:0]    reg_write_en;
    logic [5*LANES-1:0]  reg_write_addr;
    logic [8*LANES-1:0]  aluop;
    logic [3*LANES-1:0]  alusel;
    logic [32*LANES-1:0] imm;
    logic [LANES-1:0]    reg1_read_en;
    logic [5*LANES-1:0]  reg1_read_addr;
    logic [LANES-1:0]    reg2_read_en;
    logic [5*LANES-1:0]  reg2_read_addr;
    logic [LANES-1:0]    is_privilege;
    logic [LANES-1:0]    csr_read_en;
    logic [LANES-1:0]    csr_write_en;
    logic [14*LANES-1:0] csr_addr;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    decode_2ri14_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .pc_out(pc_out), .inst_out(inst_out),
        .inst_valid(inst_valid), .is_exception(is_exception),
        .exception_cause(exception_cause), .reg_write_en(reg_write_en),
        .reg_write_addr(reg_write_addr), .aluop(aluop), .alusel(alusel), .imm(imm),
        .reg1_read_en(reg1_read_en), .reg1_read_addr(reg1_read_addr),
        .reg2_read_en(reg2_read_en), .reg2_read_addr(reg2_read_addr),
        .is_privilege(is_privilege), .csr_read_en(csr_read_en),
        .csr_write_en(csr_write_en), .csr_addr(csr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference decoder written from the instruction-group description
    function automatic exp_t modelDecode(input logic [31:0] pc, input logic [31:0] inst);
        exp_t        e;
        logic [7:0]  op;
        logic [13:0] si;
        logic [4:0]  rj;
        logic [4:0]  rd;
        op = inst[31:24];
        si = inst[23:10];
        rj = inst[9:5];
        rd = inst[4:0];
        e = '0;
        e.pc = pc;
        e.inst = inst;
        if (op == 8'h20 || op == 8'h21) begin
            e.iv = 1'b1;
            e.aluop = (op == 8'h20) ? ALU_LLW : ALU_SCW;
            e.alusel = ALU_SEL_LOAD_STORE;
            e.r1e = 1'b1; e.r1a = rj;
            e.rwe = 1'b1; e.rwa = rd;
            e.imm = {{16{si[13]}}, si, 2'b00};
            e.cre = 1'b1; e.caddr = CSR_LLBCTL;
            if (op == 8'h21) begin
                e.r2e = 1'b1; e.r2a = rd;
            end
        end else if (op == 8'h04) begin
            e.iv = 1'b1; e.priv = 1'b1; e.caddr = si;
            e.rwe = 1'b1; e.rwa = rd; e.cre = 1'b1; e.alusel = ALU_SEL_CSR;
            if (rj == 5'd0) begin
                e.aluop = ALU_CSRRD;
            end else begin
                e.aluop = (rj == 5'd1) ? ALU_CSRWR : ALU_CSRXCHG;
                e.r1e = 1'b1; e.r1a = rd; e.cwe = 1'b1;
                if (rj != 5'd1) begin
                    e.r2e = 1'b1; e.r2a = rj;
                end
            end
        end else begin
            e.exc = 1'b1; e.cause = EXCEPTION_INE;
            e.aluop = ALU_NOP; e.alusel = ALU_SEL_NOP;
        end
        return e;
    endfunction

    function automatic int presentCount();
        int n;
        n = (expQ.size() < LANES) ? expQ.size() : LANES;
        if (n > 0 && expQ[0].cwe) n = 1;
        else if (n == 2 && expQ[1].cwe) n = 1;
        return n;
    endfunction

    task automatic checkLane(input int k, input exp_t e);
        checkOutput($sformatf("l%0d_pc", k), 64'(pc_out[k*32 +: 32]), 64'(e.pc));
        checkOutput($sformatf("l%0d_inst", k), 64'(inst_out[k*32 +: 32]), 64'(e.inst));
        checkOutput($sformatf("l%0d_inst_valid", k), 64'(inst_valid[k]), 64'(e.iv));
        checkOutput($sformatf("l%0d_is_exception", k), 64'(is_exception[k]), 64'(e.exc));
        checkOutput($sformatf("l%0d_cause", k), 64'(exception_cause[k*7 +: 7]), 64'(e.cause));
        checkOutput($sformatf("l%0d_rwe", k), 64'(reg_write_en[k]), 64'(e.rwe));
        checkOutput($sformatf("l%0d_rwa", k), 64'(reg_write_addr[k*5 +: 5]), 64'(e.rwa));
        checkOutput($sformatf("l%0d_aluop", k), 64'(aluop[k*8 +: 8]), 64'(e.aluop));
        checkOutput($sformatf("l%0d_alusel", k), 64'(alusel[k*3 +: 3]), 64'(e.alusel));
        checkOutput($sformatf("l%0d_imm", k), 64'(imm[k*32 +: 32]), 64'(e.imm));
        checkOutput($sformatf("l%0d_r1e", k), 64'(reg1_read_en[k]), 64'(e.r1e));
        checkOutput($sformatf("l%0d_r1a", k), 64'(reg1_read_addr[k*5 +: 5]), 64'(e.r1a));
        checkOutput($sformatf("l%0d_r2e", k), 64'(reg2_read_en[k]), 64'(e.r2e));
        checkOutput($sformatf("l%0d_r2a", k), 64'(reg2_read_addr[k*5 +: 5]), 64'(e.r2a));
        checkOutput($sformatf("l%0d_priv", k), 64'(is_privilege[k]), 64'(e.priv));
        checkOutput($sformatf("l%0d_cre", k), 64'(csr_read_en[k]), 64'(e.cre));
        checkOutput($sformatf("l%0d_cwe", k), 64'(csr_write_en[k]), 64'(e.cwe));
        checkOutput($sformatf("l%0d_caddr", k), 64'(csr_addr[k*14 +: 14]), 64'(e.caddr));
    endtask

    task automatic checkCycle();
        int n;
        logic [1:0] mask;
        n = presentCount();
        mask = (n == 0) ? 2'b00 : ((n == 1) ? 2'b01 : 2'b11);
        checkOutput("out_valid", 64'(out_valid), 64'(mask));
        checkOutput("in_ready", 64'(in_ready), 64'(expQ.size() <= DEPTH - LANES));
        for (int k = 0; k < n; k++) checkLane(k, expQ[k]);
    endtask

    // One clock: compare current outputs, drive inputs, advance the model
    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                                 input logic [31:0] p0, input logic [31:0] p1,
                                 input logic fl, input logic ordy);
        int   n;
        logic rdy;
        checkCycle();
        in_valid  = v;
        in_inst   = {i1, i0};
        in_pc     = {p1, p0};
        flush     = fl;
        out_ready = ordy;
        n   = presentCount();
        rdy = (expQ.size() <= DEPTH - LANES);
        if (fl) begin
            expQ.delete();
        end else begin
            if (ordy && n > 0) begin
                for (int j = 0; j < n; j++) expQ.delete(0);
            end
            if (v[0] && rdy) begin
                expQ.push_back(modelDecode(p0, i0));
                if (v[1]) expQ.push_back(modelDecode(p1, i1));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    function automatic logic [31:0] randInst();
        logic [7:0]  op;
        logic [13:0] si;
        logic [4:0]  rj;
        logic [4:0]  rd;
        si = 14'($urandom);
        rj = 5'($urandom);
        rd = 5'($urandom);
        case ($urandom_range(0, 5))
            0: return {8'h20, si, rj, rd};
            1: return {8'h21, si, rj, rd};
            2: return {8'h04, si, 5'd0, rd};
            3: return {8'h04, si, 5'd1, rd};
            4: return {8'h04, si, 5'(2 + $urandom_range(0, 29)), rd};
            default: begin
                op = 8'($urandom);
                if (op == 8'h20 || op == 8'h21 || op == 8'h04) op = 8'hFF;
                return {op, si, rj, rd};
            end
        endcase
    endfunction

    initial begin
        logic [1:0] v;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid = 2'b11;
        in_inst = {32'h21000861, 32'h20000482};
        in_pc = {32'h1C000004, 32'h1C000000};

        // Reset holds everything idle even with valid fetches offered
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'(2'b00));
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_inst_valid", 64'(inst_valid), 64'(2'b00));
        checkOutput("rst_is_exception", 64'(is_exception), 64'(2'b11));
        checkOutput("rst_cause0", 64'(exception_cause[6:0]), 64'(EXCEPTION_INE));
        checkOutput("rst_pc_out", 64'(pc_out), 64'd0);
        checkOutput("rst_aluop", 64'(aluop), 64'd0);
        rst_n = 1'b1;

        // First bundle after release appears one cycle later
        applyStimulus(2'b11, 32'h20000482, 32'h21000861, 32'h1C000000, 32'h1C000004, 1'b0, 1'b0);
        checkOutput("post_rst_out_valid", 64'(out_valid), 64'(2'b11));
        idle(2);

        // LL.W on lane 0
        applyStimulus(2'b01, 32'h20000482, 32'h0, 32'h1C000000, 32'h0, 1'b0, 1'b0);
        checkOutput("llw_aluop", 64'(aluop[7:0]), 64'(ALU_LLW));
        checkOutput("llw_r1a", 64'(reg1_read_addr[4:0]), 64'd4);
        checkOutput("llw_rwa", 64'(reg_write_addr[4:0]), 64'd2);
        checkOutput("llw_imm", 64'(imm[31:0]), 64'h4);
        checkOutput("llw_caddr", 64'(csr_addr[13:0]), 64'(CSR_LLBCTL));
        checkOutput("llw_inst_valid", 64'(inst_valid[0]), 64'd1);
        idle(2);

        // CSRWR followed by LL.W must be split across two cycles
        applyStimulus(2'b11, 32'h04000423, 32'h20000482, 32'h1C000010, 32'h1C000014, 1'b0, 1'b1);
        checkOutput("csr_split_valid1", 64'(out_valid), 64'(2'b01));
        checkOutput("csr_split_cwe", 64'(csr_write_en[0]), 64'd1);
        checkOutput("csr_split_r1a", 64'(reg1_read_addr[4:0]), 64'd3);
        applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("csr_split_valid2", 64'(out_valid), 64'(2'b01));
        checkOutput("csr_split_lane0", 64'(aluop[7:0]), 64'(ALU_LLW));
        idle(2);

        // Illegal opcode
        applyStimulus(2'b11, 32'hFFFFFFFF, 32'h21FFFC41, 32'h1C000020, 32'h1C000024, 1'b0, 1'b0);
        checkOutput("ine_inst_valid", 64'(inst_valid[0]), 64'd0);
        checkOutput("ine_is_exception", 64'(is_exception[0]), 64'd1);
        checkOutput("ine_cause", 64'(exception_cause[6:0]), 64'(EXCEPTION_INE));
        checkOutput("ine_rwe", 64'(reg_write_en[0]), 64'd0);
        idle(2);

        // Backpressure to full, then drain with new bundles across the wrap
        applyStimulus(2'b11, 32'h20000482, 32'h21000861, 32'h1C000100, 32'h1C000104, 1'b0, 1'b0);
        applyStimulus(2'b11, 32'h20001CA5, 32'h21FFF8C7, 32'h1C000108, 32'h1C00010C, 1'b0, 1'b0);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        applyStimulus(2'b11, 32'h20000001, 32'h21000002, 32'h1C000110, 32'h1C000114, 1'b0, 1'b1);
        applyStimulus(2'b11, 32'h20000003, 32'h21000004, 32'h1C000118, 32'h1C00011C, 1'b0, 1'b1);
        applyStimulus(2'b11, 32'h20000005, 32'h21000006, 32'h1C000120, 32'h1C000124, 1'b0, 1'b1);
        idle(4);

        // Flush at count 3 drops the queue and the incoming bundle
        applyStimulus(2'b11, 32'h20000482, 32'h21000861, 32'h1C000200, 32'h1C000204, 1'b0, 1'b0);
        applyStimulus(2'b01, 32'h04000003, 32'h0, 32'h1C000208, 32'h0, 1'b0, 1'b0);
        applyStimulus(2'b11, 32'h20000007, 32'h21000008, 32'h1C000210, 32'h1C000214, 1'b1, 1'b1);
        checkOutput("flush_out_valid", 64'(out_valid), 64'(2'b00));
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        idle(2);

        // Random traffic through the scoreboard
        for (int c = 0; c < 300; c++) begin
            case ($urandom_range(0, 2))
                0: v = 2'b00;
                1: v = 2'b01;
                default: v = 2'b11;
            endcase
            applyStimulus(v, randInst(), randInst(), $urandom, $urandom,
                          ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
        end
        idle(4);

        // Reset in the middle of operation discards queued entries
        applyStimulus(2'b11, 32'h20000482, 32'h21000861, 32'h1C000300, 32'h1C000304, 1'b0, 1'b0);
        applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'(2'b00));
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(2'b01, 32'h20000482, 32'h0, 32'h1C000400, 32'h0, 1'b0, 1'b0);
        checkOutput("midrst_reaccept", 64'(out_valid), 64'(2'b01));
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_2ri14_queue.md
DECODE_2RI14_QUEUE -- requirements
Module: decode_2ri14_queue

Interface
REQ-001 SHALL provide parameter LANES, default 2, meaning instructions accepted and presented per cycle (legal 1..4).
REQ-002 SHALL provide parameter DEPTH, default 4, meaning decoded-entry queue capacity (power of 2, DEPTH >= LANES).
REQ-003 SHALL have ports clk (input, 1, sole clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-004 SHALL have ports in_valid (input, LANES, per-lane fetch valid; lane k valid requires lane k-1 valid), in_pc (input, 32*LANES), in_inst (input, 32*LANES) and in_ready (output, 1, whole bundle accepted).
REQ-005 SHALL have ports flush (input, 1, discard all queued and incoming entries) and out_ready (input, 1, consumer takes every presented lane).
REQ-006 SHALL have per-lane outputs, packed LANES wide: out_valid (1), pc_out (32), inst_out (32), inst_valid (1), is_exception (1), exception_cause (7), reg_write_en (1), reg_write_addr (5), aluop (8), alusel (3), imm (32), reg1_read_en (1), reg1_read_addr (5), reg2_read_en (1), reg2_read_addr (5), is_privilege (1), csr_read_en (1), csr_write_en (1), csr_addr (14).

Function
REQ-007 SHALL decode opcode = inst[31:24], si14/csr = inst[23:10], rj = inst[9:5], rd = inst[4:0]; aluop/alusel/cause/CSR codes from defines.vh.
REQ-008 SHALL decode LL.W (8'h20): ALU_LLW, ALU_SEL_LOAD_STORE, reg1=rj, write rd, imm = sext(si14,2'b00), csr_read_en=1, csr_addr=CSR_LLBCTL, is_privilege=0.
REQ-009 SHALL decode SC.W (8'h21): ALU_SCW, ALU_SEL_LOAD_STORE, reg1=rj, reg2=rd, write rd, imm = sext(si14,2'b00), csr_read_en=1, csr_addr=CSR_LLBCTL.
REQ-010 SHALL decode CSR (8'h04) with is_privilege=1, csr_addr=csr, imm=0, write rd, csr_read_en=1, alusel=ALU_SEL_CSR: rj=0 -> ALU_CSRRD, no reg reads, csr_write_en=0; rj=1 -> ALU_CSRWR, reg1=rd, csr_write_en=1; else ALU_CSRXCHG, reg1=rd, reg2=rj, csr_write_en=1.
REQ-011 SHALL for any other opcode output inst_valid=0, is_exception=1, exception_cause=EXCEPTION_INE, all enables 0, aluop=ALU_NOP, alusel=ALU_SEL_NOP, imm=0, addresses 0.
REQ-012 SHALL decode combinationally at input and store decoded entries in a circular queue with head/tail pointers wrapping modulo DEPTH and occupancy count 0..DEPTH.
REQ-013 SHALL drive in_ready = (DEPTH - count) >= LANES, using pre-dequeue count; simultaneous enqueue/dequeue when count = DEPTH-LANES+1 SHALL still deassert in_ready.
REQ-014 SHALL enqueue, on an edge with in_valid[0] & in_ready & !flush, exactly the valid lanes in lane order; latency fetch-accept to out_valid = 1 cycle.
REQ-015 SHALL present up to LANES head entries in order on lanes 0..LANES-1; out_valid[k] implies out_valid[k-1]; outputs driven from queue storage only.
REQ-016 SHALL serialise CSR writers: an entry with csr_write_en=1 is presented only on lane 0 and alone; an entry behind it waits until the following cycle.
REQ-017 SHALL, on out_ready & out_valid[0], dequeue all presented lanes; out_ready with out_valid[0]=0 has no effect.
REQ-018 SHALL on flush clear count and pointers at the next edge, drop any same-cycle enqueue and dequeue, and show out_valid=0 the following cycle.
REQ-019 SHALL never overflow or underflow; count changes by (enqueued - dequeued) per edge.

Reset
REQ-020 SHALL, while rst_n=0 (asynchronously), hold count=0, pointers=0, out_valid=0, and all per-lane decode outputs at the REQ-011 values with pc_out=inst_out=0; in_ready=1 once count=0.
REQ-021 SHALL, on reset mid-operation, discard all queued entries; first acceptance occurs on the first edge after rst_n rises.

Verification
REQ-022 Reset: rst_n=0 with in_valid=2'b11 -> out_valid=0, in_ready=1, nothing enqueued; after release the next valid bundle appears one cycle later.
REQ-023 LL.W: lane0 inst 0x20000482 pc 0x1C000000 -> lane0 aluop=ALU_LLW, reg1_read_addr=4, reg_write_addr=2, imm=0x00000004, csr_addr=CSR_LLBCTL, inst_valid=1.
REQ-024 CSR split: lane0 0x04000423 (CSRWR csr 1, rd 3), lane1 LL.W 0x20000482, out_ready=1 -> cycle 1 out_valid=2'b01, csr_write_en=1, reg1_read_addr=3; cycle 2 LL.W on lane0, out_valid=2'b01.
REQ-025 Illegal: lane0 0xFFFFFFFF -> inst_valid=0, is_exception=1, exception_cause=EXCEPTION_INE, reg_write_en=0.
REQ-026 Backpressure/wrap: LANES=2, DEPTH=4, out_ready=0, two full bundles -> count=4, in_ready=0; then out_ready=1 for 3 cycles with new bundles -> order preserved across pointer wrap.
REQ-027 Flush: count=3, flush=1 with in_valid=2'b11, out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, incoming bundle absent.
